// File: rtl/instr_encoder.sv
// instr_encoder: packs instruction fields into 32-bit words using the core's
// opcode map and streams them into instruction memory from address 0 upward.
//
// Optional feature (macro INSTR_ENCODER_DELAY_SLOT_EN): after every BEQ, JR,
// J or JAL word a NOP (32'h0) is written at the next address.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start                 one-cycle pulse: restart loading at address 0
//   in_valid / in_ready   field bundle handshake
//   in_kind .. in_target  instruction fields (kind 0..8 legal, 9..15 illegal)
//   imem_we / imem_ready  memory write handshake
//   imem_addr, imem_wdata word address and encoded word
//   count, full           words written since start, count == DEPTH
//   err_kind              sticky: an illegal kind was accepted
//   dbg_state             current FSM state (IDLE=0, LOAD=1, FULL=2)
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both 1. Once raised, imem_we holds its address and data unchanged until a
// transfer occurs. in_ready does not depend on in_valid.
module instr_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              imem_we,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err_kind,
    output logic [1:0]        dbg_state
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    state_t            state_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [ADDR_W:0]   count_q;
    logic              full_q;
    logic              err_q;

    logic [ADDR_W-1:0] addr_d;
    logic [ADDR_W:0]   count_d;
    logic              done;
    logic              last_done;
    logic              accept;
    logic              enc_legal;
    logic              enc_ctrl;
    logic [31:0]       enc_word;
    logic              slot_busy;

    assign addr_d    = addr_q + 1'b1;
    assign count_d   = count_q + 1'b1;
    assign done      = we_q && imem_ready;
    // The write completing into the last slot makes full next cycle; refusing
    // a bundle in that same cycle keeps a word from being accepted with
    // nowhere to go.
    assign last_done = done && (count_q == LAST_CNT);

    always_comb begin
        enc_word  = 32'h0;
        enc_legal = 1'b1;
        enc_ctrl  = 1'b0;
        case (in_kind)
            4'd0: enc_word = {6'b000000, in_rs, in_rt, in_rd, in_shamt, in_funct};
            4'd1: enc_word = {6'b100011, in_rs, in_rt, in_imm};
            4'd2: enc_word = {6'b001000, in_rs, in_rt, in_imm};
            4'd3: enc_word = {6'b001100, in_rs, in_rt, in_imm};
            4'd4: enc_word = {6'b001101, in_rs, in_rt, in_imm};
            4'd5: begin
                enc_word = {6'b000100, in_rs, in_rt, in_imm};
                enc_ctrl = 1'b1;
            end
            4'd6: begin
                enc_word = {6'b100000, in_rs, 21'b0};
                enc_ctrl = 1'b1;
            end
            4'd7: begin
                enc_word = {6'b110000, in_target};
                enc_ctrl = 1'b1;
            end
            4'd8: begin
                enc_word = {6'b111000, in_target};
                enc_ctrl = 1'b1;
            end
            default: enc_legal = 1'b0;
        endcase
    end

`ifdef INSTR_ENCODER_DELAY_SLOT_EN
    logic ctrl_q;  // pending word is a control transfer
    logic nop_q;   // pending word is the padding NOP
    // Input is held off from the control word's write until its NOP is done.
    assign slot_busy = we_q && (ctrl_q || nop_q);
`else
    assign slot_busy = 1'b0;
`endif

    assign in_ready = (state_q == ST_LOAD) && !full_q && !start && !last_done &&
                      !slot_busy && (!we_q || imem_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            count_q <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef INSTR_ENCODER_DELAY_SLOT_EN
            ctrl_q  <= 1'b0;
            nop_q   <= 1'b0;
`endif
        end else if (start) begin
            // Restart drops whatever write was pending.
            state_q <= ST_LOAD;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            count_q <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef INSTR_ENCODER_DELAY_SLOT_EN
            ctrl_q  <= 1'b0;
            nop_q   <= 1'b0;
`endif
        end else begin
            if (done) begin
                addr_q  <= addr_d;   // wraps to 0 on the last slot; unused while full
                count_q <= count_d;
                if (count_q == LAST_CNT) begin
                    full_q  <= 1'b1;
                    state_q <= ST_FULL;
                end
            end
`ifdef INSTR_ENCODER_DELAY_SLOT_EN
            if (accept && enc_legal) begin
                we_q    <= 1'b1;
                wdata_q <= enc_word;
                ctrl_q  <= enc_ctrl;
                nop_q   <= 1'b0;
            end else if (done && ctrl_q && (count_q != LAST_CNT)) begin
                we_q    <= 1'b1;
                wdata_q <= 32'h0;
                ctrl_q  <= 1'b0;
                nop_q   <= 1'b1;
            end else if (done) begin
                we_q    <= 1'b0;
                ctrl_q  <= 1'b0;
                nop_q   <= 1'b0;
            end
`else
            if (accept && enc_legal) begin
                we_q    <= 1'b1;
                wdata_q <= enc_word;
            end else if (done) begin
                we_q    <= 1'b0;
            end
`endif
            if (accept && !enc_legal) begin
                err_q <= 1'b1;
            end
        end
    end

`ifndef INSTR_ENCODER_DELAY_SLOT_EN
    // Control-word tracking only matters for padding.
    logic unused_ctrl;
    assign unused_ctrl = enc_ctrl;
`endif

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign count      = count_q;
    assign full       = full_q;
    assign err_kind   = err_q;
    assign dbg_state  = state_q;

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the opcode decoder: takes instruction fields (kind, register numbers, immediate/target) and encodes them into 32-bit instruction words.
- Uses the core's opcode map; encoded words are written sequentially into instruction memory through a write port with backpressure.
- Used at bring-up and by test loaders to fill program memory from a host/UART front end.
- Sequential elements: one-deep output register, address/count counters, 3-state FSM.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; DEPTH = 2**ADDR_W words.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse: restart loading at address 0.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder accepts the bundle this cycle.
- in_kind  in  4  0=R, 1=LW, 2=ADDI, 3=ANDI, 4=ORI, 5=BEQ, 6=JR, 7=J, 8=JAL; 9–15 illegal.
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register/shift fields.
- in_funct  in  6  R-type function field.
- in_imm  in  16  I-type immediate/branch offset.
- in_target  in  26  J/JAL target.
- imem_we  out  1  write request.
- imem_ready  in  1  memory accepts the write this cycle.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  encoded word.
- count  out  ADDR_W+1  words written since start.
- full  out  1  count == DEPTH.
- err_kind  out  1  sticky flag: illegal kind seen.

Behaviour:
- Reset (async, rst_n=0): state IDLE; imem_we=0, imem_addr=0, imem_wdata=0, count=0, full=0, err_kind=0, in_ready=0.
- FSM states: IDLE, LOAD, FULL.
  - IDLE: in_ready=0; start -> LOAD.
  - LOAD: in_ready = !full && (!imem_we || imem_ready).
  - FULL: in_ready=0; only start or reset leaves it.
- Encoding:
  - R: {000000, rs, rt, rd, shamt, funct}.
  - LW / ADDI / ANDI / ORI / BEQ: opcode 100011 / 001000 / 001100 / 001101 / 000100, then {op, rs, rt, imm}.
  - JR: {100000, rs, 21'b0}.
  - J: {110000, target}.
  - JAL: {111000, target}.
  - Fields not used by a kind are ignored.
- Latency: a bundle accepted (in_valid && in_ready) in cycle N drives imem_we=1 with the word in cycle N+1. imem_we, imem_addr and imem_wdata stay stable until imem_ready=1.
- Accept and complete in the same cycle is allowed, giving full throughput of 1 word/cycle.
- On each completed write (imem_we && imem_ready):
  - imem_addr and count increment.
  - When count reaches DEPTH, full=1 and the state goes to FULL.
  - imem_addr wraps to 0 but is never used while full.
- Illegal kind: accepted, nothing written, no counter change, err_kind set.
- start in any state has priority over everything else:
  - Any pending write is dropped (imem_we=0 the next cycle).
  - imem_addr, count, full and err_kind are cleared; state -> LOAD.
  - A bundle presented in the start cycle is not accepted (in_ready=0 that cycle).
- rst_n asserted mid-write: the write is abandoned immediately (async clear).

Optional Feature:
- Macro: INSTR_ENCODER_DELAY_SLOT_EN.
- Defined:
  - After any BEQ, JR, J or JAL write completes, the encoder writes 32'h00000000 (NOP) at the next address.
  - in_ready=0 until the NOP write completes; the NOP counts toward count/full.
  - If the control word fills the last address, no NOP is written and the state goes to FULL.
- Undefined: no padding; control-transfer words are written back-to-back like others.

Test Plan:
- start, then ADDI rs=1 rt=2 imm=0x0005 -> imem_we next cycle, addr 0, wdata 0x20220005; count=1 after imem_ready.
- R rs=1 rt=2 rd=3 shamt=0 funct=0x20, then LW rs=3 rt=4 imm=0x0010, imem_ready held 1 -> addr 0: 0x00221820, addr 1: 0x8C640010 on consecutive cycles; in_ready stays 1.
- BEQ rs=1 rt=2 imm=0xFFFF with imem_ready=0 for 3 cycles -> 0x1022FFFF held stable, in_ready=0 during the stall, addr advances only after imem_ready.
- J target=0x100, JAL target=0x40, JR rs=31 -> 0xC0000100, 0xE0000040, 0x83E00000. With INSTR_ENCODER_DELAY_SLOT_EN, each is followed by 0x00000000 (6 writes, count=6).
- ADDR_W=2, 5 legal bundles -> 4 writes, full=1 after the 4th, in_ready=0, the 5th is not accepted; start -> count=0, addr=0, in_ready=1.
- in_kind=12 -> no write, err_kind=1 and it stays set; rst_n pulsed low during a stalled write -> imem_we=0 immediately, all outputs at reset values.
